// File: rtl/loader_pkg.sv
// loader_pkg
// Shared definitions for the instruction encoder/loader:
//   - instruction kind codes presented on in_kind
//   - MIPS primary opcodes, matching the core's control decoder
//   - loader FSM state encoding
package loader_pkg;

    // Instruction kinds offered on in_kind; 10..15 are illegal.
    localparam logic [3:0] KIND_R    = 4'd0;
    localparam logic [3:0] KIND_ADDI = 4'd1;
    localparam logic [3:0] KIND_ORI  = 4'd2;
    localparam logic [3:0] KIND_LUI  = 4'd3;
    localparam logic [3:0] KIND_BEQ  = 4'd4;
    localparam logic [3:0] KIND_BNE  = 4'd5;
    localparam logic [3:0] KIND_LW   = 4'd6;
    localparam logic [3:0] KIND_SW   = 4'd7;
    localparam logic [3:0] KIND_J    = 4'd8;
    localparam logic [3:0] KIND_JAL  = 4'd9;

    // Primary opcodes (instruction bits 31:26).
    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] I_ADDI = 6'h08;
    localparam logic [5:0] I_ORI  = 6'h0D;
    localparam logic [5:0] I_LUI  = 6'h0F;
    localparam logic [5:0] I_BEQ  = 6'h04;
    localparam logic [5:0] I_BNE  = 6'h05;
    localparam logic [5:0] I_LW   = 6'h23;
    localparam logic [5:0] I_SW   = 6'h2B;
    localparam logic [5:0] J_JUMP = 6'h02;
    localparam logic [5:0] J_JAL  = 6'h03;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } loaderState_e;

endpackage

// File: rtl/instr_encoder_loader_sync_fifo.sv
// sync_fifo
// Single-clock FIFO holding encoded instruction words between the field
// input and the memory write port. The head word is presented
// combinationally so it can sit on the memory bus until it is popped.
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-low reset
//   flush          synchronous clear; wins over push/pop on the same edge
//   push, pushData write pushData at the tail (ignored when full)
//   pop            drop the head word (ignored when empty)
//   full, empty    occupancy flags
//   head           word at the head (undefined content while empty)
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic             doPush;
    logic             doPop;

    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = store[rdPtr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers/count decide what is valid.
    always_ff @(posedge clk) begin
        if (doPush && !flush) store[wrPtr] <= pushData;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Packs instruction fields into 32-bit MIPS words (R/I/J formats) and writes
// them to instruction memory at consecutive word addresses, through a small
// FIFO. Used to load programs before the core runs.
// Handshakes:
//   input  : a field set transfers on a rising edge where in_valid && in_ready.
//   memory : a word retires on a rising edge where mem_we && mem_ready;
//            mem_we/mem_addr/mem_wdata hold steady until then.
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   start, finish          control pulses (start flushes and (re)enters LOAD)
//   in_*                   instruction fields and kind
//   mem_*                  instruction memory write port
//   word_count             words retired since start (saturating)
//   busy, done             LOAD/DRAIN and DONE status
//   err_illegal, err_wrap  sticky error flags
//   dbgState               current FSM state
module instr_encoder_loader
    import loader_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0040_0000,
    parameter int          MEM_WORDS  = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         finish,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_kind,
    input  logic [4:0]                   in_rs,
    input  logic [4:0]                   in_rt,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_shamt,
    input  logic [5:0]                   in_funct,
    input  logic [15:0]                  in_imm,
    input  logic [25:0]                  in_target,
    output logic                         mem_we,
    input  logic                         mem_ready,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [$clog2(MEM_WORDS):0]   word_count,
    output logic                         busy,
    output logic                         done,
    output logic                         err_illegal,
    output logic                         err_wrap,
    output logic [1:0]                   dbgState
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MEM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    function automatic logic [31:0] encodeWord(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = '0;
        case (kind)
            KIND_R:    w = {R_TYPE, rs, rt, rd, shamt, funct};
            KIND_ADDI: w = {I_ADDI, rs, rt, imm};
            KIND_ORI:  w = {I_ORI,  rs, rt, imm};
            KIND_LUI:  w = {I_LUI,  5'd0, rt, imm};  // LUI has no source register
            KIND_BEQ:  w = {I_BEQ,  rs, rt, imm};
            KIND_BNE:  w = {I_BNE,  rs, rt, imm};
            KIND_LW:   w = {I_LW,   rs, rt, imm};
            KIND_SW:   w = {I_SW,   rs, rt, imm};
            KIND_J:    w = {J_JUMP, target};
            KIND_JAL:  w = {J_JAL,  target};
            default:   w = '0;
        endcase
        return w;
    endfunction

    loaderState_e     state;
    loaderState_e     stateNext;
    logic [IDX_W-1:0] index;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [31:0]      fifoHead;
    logic             accept;
    logic             kindLegal;
    logic             retire;

    assign kindLegal = (in_kind <= KIND_JAL);
    assign accept    = in_valid && in_ready;
    assign retire    = mem_we && mem_ready;
    assign dbgState  = state;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (start),
        .push     (accept && kindLegal && !start),
        .pushData (encodeWord(in_kind, in_rs, in_rt, in_rd, in_shamt,
                              in_funct, in_imm, in_target)),
        .pop      (retire && !start),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .head     (fifoHead)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: ;
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = !fifoFull;
                mem_we   = !fifoEmpty;
                if (finish) stateNext = S_DRAIN;
            end
            S_DRAIN: begin
                busy   = 1'b1;
                mem_we = !fifoEmpty;
                // An empty FIFO means nothing is on the bus either.
                if (fifoEmpty) stateNext = S_DONE;
            end
            S_DONE:  done = 1'b1;
            default: stateNext = S_IDLE;
        endcase
        if (start) stateNext = S_LOAD;
    end

    assign mem_addr  = BASE_ADDR + {{(30-IDX_W){1'b0}}, index, 2'b00};
    assign mem_wdata = mem_we ? fifoHead : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index       <= '0;
            word_count  <= '0;
            err_illegal <= 1'b0;
            err_wrap    <= 1'b0;
        end else if (start) begin
            index       <= '0;
            word_count  <= '0;
            err_illegal <= 1'b0;
            err_wrap    <= 1'b0;
        end else begin
            if (accept && !kindLegal) err_illegal <= 1'b1;
            if (retire) begin
                index <= index + 1'b1;  // power-of-two size wraps naturally
                if (index == IDX_LAST) err_wrap <= 1'b1;
                if (word_count != CNT_MAX) word_count <= word_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int          FIFO_DEPTH = 4;
    localparam int          MEM_WORDS  = 4;
    localparam logic [31:0] BASE       = 32'h0040_0000;
    localparam int          WC_MAX     = 2 * MEM_WORDS - 1;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0, mem_ready = 1'b0;
    logic [3:0]  in_kind = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]  in_funct = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_ready, mem_we, busy, done, err_illegal, err_wrap;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  word_count;
    logic [1:0]  dbgState;

    always #5 clk = ~clk;

    instr_encoder_loader #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BASE_ADDR  (BASE),
        .MEM_WORDS  (MEM_WORDS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_count(word_count), .busy(busy),
        .done(done), .err_illegal(err_illegal), .err_wrap(err_wrap),
        .dbgState(dbgState)
    );

    // ---------------- checking ----------------
    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference encoding built from field weights (opcode<<26, rs<<21, ...).
    function automatic logic [31:0] refEncode(input int kind, input int rs, input int rt,
                                              input int rd, input int sh, input int fn,
                                              input int imm, input int tgt);
        int     ops[10] = '{0, 8, 13, 15, 4, 5, 35, 43, 2, 3};
        longint w;
        if (kind == 0)
            w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
              + longint'(sh) * 64 + longint'(fn);
        else if (kind >= 8)
            w = longint'(ops[kind]) * 67108864 + longint'(tgt);
        else
            w = longint'(ops[kind]) * 67108864 + longint'(kind == 3 ? 0 : rs) * 2097152
              + longint'(rt) * 65536 + longint'(imm);
        return 32'(w);
    endfunction

    // ---------------- reference model + scoreboard ----------------
    // mSt: 0 idle, 1 load, 2 drain, 3 done. expQ holds words buffered in the loader.
    logic [31:0] expQ[$];
    int          mSt = 0;
    int          retired = 0;
    bit          mIll = 0, mWrap = 0;
    logic [31:0] obsAddr[64];
    logic [31:0] obsData[64];
    int          obsN = 0;

    always @(negedge clk) begin
        int sz;
        bit acc, ret, expWe;
        if (!reset) begin
            mSt = 0; expQ.delete(); retired = 0; mIll = 0; mWrap = 0;
        end
        expWe = (expQ.size() > 0) && (mSt == 1 || mSt == 2);
        check("in_ready", in_ready, (mSt == 1) && (expQ.size() < FIFO_DEPTH));
        check("mem_we", mem_we, expWe);
        check("mem_addr", mem_addr, 32'(BASE + 4 * (retired % MEM_WORDS)));
        if (expWe)  check("mem_wdata", mem_wdata, expQ[0]);
        if (!reset) check("mem_wdata_reset", mem_wdata, 32'd0);
        check("busy", busy, mSt == 1 || mSt == 2);
        check("done", done, mSt == 3);
        check("err_illegal", err_illegal, mIll);
        check("err_wrap", err_wrap, mWrap);
        check("word_count", word_count, retired > WC_MAX ? WC_MAX : retired);
        if (reset) begin
            if (start) begin
                mSt = 1; expQ.delete(); retired = 0; mIll = 0; mWrap = 0; obsN = 0;
            end else begin
                sz  = expQ.size();
                acc = in_valid && (mSt == 1) && (sz < FIFO_DEPTH);
                ret = expWe && mem_ready;
                if (ret) begin
                    if (obsN < 64) begin
                        obsAddr[obsN] = mem_addr; obsData[obsN] = mem_wdata; obsN++;
                    end
                    void'(expQ.pop_front());
                    if (retired % MEM_WORDS == MEM_WORDS - 1) mWrap = 1;
                    retired++;
                end
                if (acc) begin
                    if (in_kind > 9) mIll = 1;
                    else expQ.push_back(refEncode(in_kind, in_rs, in_rt, in_rd, in_shamt,
                                                  in_funct, in_imm, in_target));
                end
                if (mSt == 1 && finish)     mSt = 2;
                else if (mSt == 2 && sz == 0) mSt = 3;
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit randReady = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (randReady) mem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic pulseStart();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulseFinish();
        finish = 1'b1; step(); finish = 1'b0;
    endtask

    task automatic setFields(input int kind, input int rs, input int rt, input int rd,
                             input int sh, input int fn, input int imm, input int tgt);
        in_kind = 4'(kind); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tgt);
    endtask

    task automatic sendOne(input int kind, input int rs, input int rt, input int rd,
                           input int sh, input int fn, input int imm, input int tgt);
        bit accepted = 0;
        setFields(kind, rs, rt, rd, sh, fn, imm, tgt);
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin accepted = 1; break; end
            step();
        end
        step();
        in_valid = 1'b0;
        check("accept_timeout", accepted, 1);
    endtask

    task automatic sendRandom(input int kmin, input int kmax);
        sendOne($urandom_range(kmin, kmax), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                $urandom_range(0, 65535), $urandom_range(0, 67108863));
    endtask

    task automatic waitEmpty();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (expQ.size() == 0) break;
        end
        step();
        check("drain_empty", mem_we, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int accepts;
        int base;
        // Reset values
        repeat (2) step();
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_word_count", word_count, 0);
        reset = 1'b1;
        step();

        // Single ADDI
        pulseStart();
        mem_ready = 1'b1;
        sendOne(1, 0, 8, 0, 0, 0, 16'h0005, 0);
        waitEmpty();
        check("addi_word", obsData[0], 32'h2008_0005);
        check("addi_addr", obsAddr[0], 32'h0040_0000);
        check("addi_count", word_count, 1);

        // R, J, JAL in order
        pulseStart();
        sendOne(0, 8, 9, 10, 0, 6'h20, 0, 0);
        sendOne(8, 0, 0, 0, 0, 0, 0, 26'h010_0000);
        sendOne(9, 0, 0, 0, 0, 0, 0, 26'h010_0003);
        waitEmpty();
        check("r_word", obsData[0], 32'h0109_5020);
        check("j_word", obsData[1], 32'h0810_0000);
        check("jal_word", obsData[2], 32'h0C10_0003);
        check("r_addr", obsAddr[0], 32'h0040_0000);
        check("j_addr", obsAddr[1], 32'h0040_0004);
        check("jal_addr", obsAddr[2], 32'h0040_0008);

        // Back-pressure: FIFO fills after 4 accepts, then drains in order
        mem_ready = 1'b0;
        accepts = 0;
        in_valid = 1'b1;
        setFields($urandom_range(0, 9), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                  $urandom_range(0, 65535), $urandom_range(0, 67108863));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_ready) accepts++;
            step();
            setFields($urandom_range(0, 9), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                      $urandom_range(0, 65535), $urandom_range(0, 67108863));
        end
        in_valid = 1'b0;
        check("bp_accepts", accepts, 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_mem_we", mem_we, 1);
        mem_ready = 1'b1;
        waitEmpty();
        check("bp_count", word_count, 7);

        // Illegal kind is dropped; next LUI forces rs to 0
        base = obsN;
        sendOne(12, 3, 4, 5, 6, 7, 16'h1234, 0);
        check("illegal_flag", err_illegal, 1);
        sendOne(3, 7, 1, 0, 0, 0, 16'h1001, 0);
        waitEmpty();
        check("lui_word", obsData[base], 32'h3C01_1001);
        check("lui_addr", obsAddr[base], 32'h0040_000C);

        // Index wrap, saturation, finish -> DRAIN -> DONE
        pulseStart();
        check("start_clears_illegal", err_illegal, 0);
        check("start_clears_wrap", err_wrap, 0);
        for (int i = 0; i < 5; i++) sendRandom(0, 9);
        waitEmpty();
        check("wrap_addr", obsAddr[4], 32'h0040_0000);
        check("wrap_flag", err_wrap, 1);
        check("wrap_count", word_count, 5);
        for (int i = 0; i < 4; i++) sendRandom(0, 9);
        waitEmpty();
        check("sat_count", word_count, 7);
        pulseFinish();
        check("drain_busy", busy, 1);
        check("drain_done", done, 0);
        step();
        check("done_flag", done, 1);
        in_valid = 1'b1;
        step();
        check("done_no_accept", in_ready, 0);
        in_valid = 1'b0;
        pulseStart();
        check("restart_count", word_count, 0);
        check("restart_wrap", err_wrap, 0);

        // Randomized run with random memory back-pressure and illegal kinds
        randReady = 1;
        for (int i = 0; i < 30; i++) sendRandom(0, 15);
        pulseFinish();
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            step();
        end
        check("rand_done", done, 1);
        randReady = 0;

        // Asynchronous reset with words buffered
        pulseStart();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) sendRandom(0, 9);
        check("pre_reset_we", mem_we, 1);
        #2 reset = 1'b0;
        #1;
        check("async_mem_we", mem_we, 0);
        check("async_in_ready", in_ready, 0);
        step();
        reset = 1'b1;
        step();
        step();
        check("post_reset_in_ready", in_ready, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_count", word_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the processor's opcode decoder: accepts instruction fields plus an instruction kind, packs them into 32-bit MIPS words (R/I/J formats), and streams them into instruction memory at sequential word addresses.
- Used by the test/boot infrastructure to load programs before the core runs.
- Buffered through a small FIFO.
- Memory side uses a valid/ready write handshake.

Parameters:
- FIFO_DEPTH, 4: encoded-word buffer entries (power of 2, ≥2).
- BASE_ADDR, 32'h0040_0000: byte address of the first word written.
- MEM_WORDS, 64: instruction memory size in words (power of 2); write index wraps at this value.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse: flush the FIFO, index=0, clear flags, enter LOAD.
- finish  in  1  pulse: no more input; drain the FIFO, then DONE.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  loader can accept fields.
- in_kind  in  4  0 R, 1 ADDI, 2 ORI, 3 LUI, 4 BEQ, 5 BNE, 6 LW, 7 SW, 8 J, 9 JAL; 10–15 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  I-type immediate.
- in_target  in  26  J-type target.
- mem_we  out  1  write request valid.
- mem_ready  in  1  memory accepts the write.
- mem_addr  out  32  byte address = BASE_ADDR + 4*index.
- mem_wdata  out  32  encoded word.
- word_count  out  $clog2(MEM_WORDS)+1  words retired since start (saturates).
- busy  out  1  state is LOAD or DRAIN.
- done  out  1  state is DONE.
- err_illegal  out  1  sticky: an illegal kind was offered.
- err_wrap  out  1  sticky: the index wrapped past MEM_WORDS-1.

Behaviour:
- Reset (async, low): state IDLE, FIFO empty, index=0, word_count=0, all flags 0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, in_ready=0.
- States:
  - IDLE: start -> LOAD.
  - LOAD: finish -> DRAIN.
  - DRAIN: FIFO empty and no write in flight -> DONE.
  - DONE: start -> LOAD.
  - start in any state -> LOAD, same-edge flush, index/word_count/flags cleared. start beats finish when both are asserted.
- in_ready = (state==LOAD) && !fifo_full. There is no push-through when full.
- Accept = in_valid && in_ready. On that edge the encoded word is pushed to the FIFO.
- Encoding (opcodes 00,08,0D,0F,04,05,23,2B,02,03):
  - R: {6'h00, rs, rt, rd, shamt, funct}.
  - I: {op, rs, rt, imm}.
  - LUI: rs forced to 0.
  - J/JAL: {op, target}.
- Illegal kind on accept: word dropped (not pushed); err_illegal set.
- Latency: field accepted at edge N -> mem_we=1 no earlier than the cycle after edge N.
- mem_we = FIFO non-empty and state ∈ {LOAD, DRAIN}. mem_wdata is the FIFO head; mem_addr is the current index.
- mem_we, mem_addr, mem_wdata are held stable until mem_ready is sampled high.
- Retire = mem_we && mem_ready:
  - pop the FIFO;
  - index+1, wrapping MEM_WORDS-1 -> 0; wrap sets err_wrap;
  - word_count+1, saturating.
- Push and pop on the same edge: occupancy unchanged, order preserved.
- finish with an empty FIFO goes to DRAIN, then DONE on the next edge. Input is not accepted in DRAIN or DONE.
- Reset mid-operation: immediate return to reset values; buffered words are lost.

Decomposition:
- Shared package (loader_pkg):
  - kind codes KIND_R..KIND_JAL;
  - opcode constants matching the control decoder (R_TYPE, I_ADDI, I_ORI, I_LUI, I_BEQ, I_BNE, I_LW, I_SW, J_JUMP, J_JAL);
  - state encoding.
- One sub-module, sync_fifo:
  - parameters WIDTH=32, DEPTH;
  - ports push/pop/flush/full/empty/head;
  - same clk/reset.
- Encoder is a combinational function in the top module.

Test Plan:
- start; push ADDI rs=0 rt=8 imm=0x0005, mem_ready=1 -> mem_wdata=0x20080005 at mem_addr=0x00400000; word_count=1.
- Push R rs=8 rt=9 rd=10 shamt=0 funct=0x20, then J target=0x0100000, then JAL target=0x0100003 -> words 0x01095020, 0x08100000, 0x0C100003 at 0x00400000/04/08, in order.
- mem_ready=0 with continuous in_valid -> in_ready drops after 4 accepts. mem_we/addr/wdata stay stable. Releasing mem_ready drains all 4 in order.
- in_kind=12 -> err_illegal=1, no mem_we for that item, index unchanged. Next LUI rt=1 imm=0x1001 (rs driven to 7) -> 0x3C011001.
- MEM_WORDS=4: write 5 words -> fifth at 0x00400000, err_wrap=1. finish -> DRAIN then DONE=1. start -> flags cleared, word_count=0.
- Reset asserted with 3 words buffered and mem_ready=0 -> mem_we=0 immediately (asynchronous). After release: IDLE, in_ready=0.
